// File: rtl/tinytpu_mv_engine.sv
// Serial matrix-vector engine: loads an N x N matrix X and an N-vector Y over LANES-bit links,
// computes Z = X*Y with a single shared MAC (optionally accumulating across runs), and streams Z out.
module tinytpu_mv_engine #(
  parameter int D_W    = 8,
  parameter int N      = 3,
  parameter int LANES  = 1,
  parameter int ACC_W  = 20,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LANES-1:0] data_in_x,
  input  logic [LANES-1:0] data_in_y,
  input  logic             load_en,
  input  logic             init,
  input  logic             acc_mode,
  input  logic             tx_hold,
  output logic [LANES-1:0] data_out_z,
  output logic             tx_ready,
  output logic             busy,
  output logic             done
);

  localparam int X_BITS  = N * N * D_W;
  localparam int Y_BITS  = N * D_W;
  localparam int L_BEATS = X_BITS / LANES;
  localparam int Y_BEATS = Y_BITS / LANES;
  localparam int T_BEATS = ACC_W / LANES;
  localparam int LB_W    = (L_BEATS > 1) ? $clog2(L_BEATS) : 1;
  localparam int K_W     = (N * N > 1) ? $clog2(N * N) : 1;
  localparam int N_W     = (N > 1) ? $clog2(N) : 1;
  localparam int TB_W    = (T_BEATS > 1) ? $clog2(T_BEATS) : 1;

  localparam logic [LB_W-1:0] L_LAST = LB_W'(L_BEATS - 1);
  localparam logic [LB_W-1:0] Y_END  = LB_W'(Y_BEATS);
  localparam logic [K_W-1:0]  K_LAST = K_W'(N * N - 1);
  localparam logic [N_W-1:0]  N_LAST = N_W'(N - 1);
  localparam logic [TB_W-1:0] T_LAST = TB_W'(T_BEATS - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMP, S_TX} state_t;

  state_t            r_state;
  logic [X_BITS-1:0] r_x;
  logic [Y_BITS-1:0] r_y;
  logic [ACC_W-1:0]  r_z [N];
  logic [LB_W-1:0]   r_lbeat;
  logic [K_W-1:0]    r_k;
  logic [N_W-1:0]    r_i;
  logic [N_W-1:0]    r_j;
  logic [N_W-1:0]    r_te;
  logic [TB_W-1:0]   r_tbeat;
  logic              r_done;

  // Shift registers fill MSB-first, so element 0 ends up in the top slice.
  logic [D_W-1:0] w_xa [N*N];
  logic [D_W-1:0] w_ya [N];

  for (genvar g = 0; g < N * N; g++) begin : g_xa
    assign w_xa[g] = r_x[(N*N-1-g)*D_W +: D_W];
  end
  for (genvar g = 0; g < N; g++) begin : g_ya
    assign w_ya[g] = r_y[(N-1-g)*D_W +: D_W];
  end

  logic [D_W-1:0]   w_x;
  logic [D_W-1:0]   w_y;
  logic [2*D_W-1:0] w_x_ext;
  logic [2*D_W-1:0] w_y_ext;
  logic [2*D_W-1:0] w_prod;
  logic             w_sign;
  logic [ACC_W-1:0] w_prod_ext;

  assign w_x = w_xa[r_k];
  assign w_y = w_ya[r_j];

  // Operands pre-extended to 2*D_W so a truncated unsigned multiply yields the signed product too.
  if (SIGNED != 0) begin : g_signed
    assign w_x_ext = {{D_W{w_x[D_W-1]}}, w_x};
    assign w_y_ext = {{D_W{w_y[D_W-1]}}, w_y};
    assign w_sign  = w_prod[2*D_W-1];
  end else begin : g_unsigned
    assign w_x_ext = {{D_W{1'b0}}, w_x};
    assign w_y_ext = {{D_W{1'b0}}, w_y};
    assign w_sign  = 1'b0;
  end

  assign w_prod = w_x_ext * w_y_ext;

  if (ACC_W > 2 * D_W) begin : g_ext
    assign w_prod_ext = {{(ACC_W-2*D_W){w_sign}}, w_prod};
  end else begin : g_noext
    assign w_prod_ext = w_prod[ACC_W-1:0];
  end

  logic [ACC_W-1:0] w_zsel;
  logic [31:0]      w_shamt;
  logic [LANES-1:0] w_zbits;

  assign w_zsel  = r_z[r_te];
  assign w_shamt = 32'(T_LAST - r_tbeat) * 32'(LANES);
  assign w_zbits = LANES'(w_zsel >> w_shamt);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_lbeat <= '0;
      r_k     <= '0;
      r_i     <= '0;
      r_j     <= '0;
      r_te    <= '0;
      r_tbeat <= '0;
      r_done  <= 1'b0;
      for (int n = 0; n < N; n++) r_z[n] <= '0;
    end else begin
      r_done <= 1'b0;
      if (init) begin
        // Start or abort: any state restarts loading; acc_mode keeps existing sums.
        r_state <= S_LOAD;
        r_lbeat <= '0;
        r_k     <= '0;
        r_i     <= '0;
        r_j     <= '0;
        r_te    <= '0;
        r_tbeat <= '0;
        if (!acc_mode) begin
          for (int n = 0; n < N; n++) r_z[n] <= '0;
        end
      end else begin
        case (r_state)
          S_IDLE: ;
          S_LOAD: begin
            if (load_en) begin
              r_x <= {r_x[X_BITS-LANES-1:0], data_in_x};
              if (r_lbeat < Y_END) r_y <= {r_y[Y_BITS-LANES-1:0], data_in_y};
              if (r_lbeat == L_LAST) begin
                r_lbeat <= '0;
                r_state <= S_COMP;
              end else begin
                r_lbeat <= r_lbeat + LB_W'(1);
              end
            end
          end
          S_COMP: begin
            r_z[r_i] <= r_z[r_i] + w_prod_ext;
            if (r_k == K_LAST) begin
              r_k     <= '0;
              r_i     <= '0;
              r_j     <= '0;
              r_te    <= '0;
              r_tbeat <= '0;
              r_state <= S_TX;
            end else begin
              r_k <= r_k + K_W'(1);
              if (r_j == N_LAST) begin
                r_j <= '0;
                r_i <= r_i + N_W'(1);
              end else begin
                r_j <= r_j + N_W'(1);
              end
            end
          end
          S_TX: begin
            if (!tx_hold) begin
              if (r_tbeat == T_LAST) begin
                r_tbeat <= '0;
                if (r_te == N_LAST) begin
                  r_te    <= '0;
                  r_state <= S_IDLE;
                  r_done  <= 1'b1;
                end else begin
                  r_te <= r_te + N_W'(1);
                end
              end else begin
                r_tbeat <= r_tbeat + TB_W'(1);
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign tx_ready   = (r_state == S_TX) && !tx_hold;
  assign data_out_z = tx_ready ? w_zbits : '0;
  assign busy       = (r_state != S_IDLE);
  assign done       = r_done;

endmodule

// File: tb/tb_tinytpu_mv_engine.sv
// Bench for tinytpu_mv_engine: unsigned and signed LANES=1 instances share stimulus, plus a LANES=4 instance.
// Expected Z elements are queued at issue time; a negedge monitor reassembles output elements and compares.
module tb_tinytpu_mv_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       x1, y1, le1, init1, acc1, hold1;
  logic [3:0] x4, y4;
  logic       le4, init4, acc4, hold4;
  logic       za, zs;
  logic [3:0] zl;
  logic       tra, trs, trl, busya, busys, busyl, donea, dones, donel;

  tinytpu_mv_engine #(.D_W(8), .N(3), .LANES(1), .ACC_W(20), .SIGNED(0)) dut_a (
    .clk(clk), .rst(rst), .data_in_x(x1), .data_in_y(y1), .load_en(le1), .init(init1),
    .acc_mode(acc1), .tx_hold(hold1), .data_out_z(za), .tx_ready(tra), .busy(busya), .done(donea));

  tinytpu_mv_engine #(.D_W(8), .N(3), .LANES(1), .ACC_W(20), .SIGNED(1)) dut_s (
    .clk(clk), .rst(rst), .data_in_x(x1), .data_in_y(y1), .load_en(le1), .init(init1),
    .acc_mode(acc1), .tx_hold(hold1), .data_out_z(zs), .tx_ready(trs), .busy(busys), .done(dones));

  tinytpu_mv_engine #(.D_W(8), .N(3), .LANES(4), .ACC_W(20), .SIGNED(0)) dut_l (
    .clk(clk), .rst(rst), .data_in_x(x4), .data_in_y(y4), .load_en(le4), .init(init4),
    .acc_mode(acc4), .tx_hold(hold4), .data_out_z(zl), .tx_ready(trl), .busy(busyl), .done(donel));

  localparam logic [71:0] X_ID  = 72'h01_00_00_00_01_00_00_00_01;
  localparam logic [71:0] X_FF  = {9{8'hFF}};
  localparam logic [71:0] X_80  = {9{8'h80}};
  localparam logic [71:0] X_SEQ = 72'h01_02_03_04_05_06_07_08_09;
  localparam logic [23:0] Y_123 = 24'h01_02_03;
  localparam logic [23:0] Y_FF  = 24'hFF_FF_FF;
  localparam logic [23:0] Y_80  = 24'h80_80_80;
  localparam logic [23:0] Y_1   = 24'h01_01_01;

  logic [19:0] q_a[$];
  logic [19:0] q_s[$];
  logic [19:0] q_l[$];

  int checks   = 0;
  int failures = 0;
  int          dn  [3] = '{0, 0, 0};
  int          txb [3] = '{0, 0, 0};
  int          bc  [3] = '{0, 0, 0};
  logic [19:0] sh  [3] = '{20'h0, 20'h0, 20'h0};

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic mon(input int id, input logic tr, input logic [3:0] d, input logic hold, input logic dn_i);
    logic [19:0] e;
    bit          got;
    int          bpe;
    bpe = (id == 2) ? 5 : 20;
    got = 1'b0;
    e   = '0;
    if (dn_i) dn[id]++;
    if (tr) begin
      txb[id]++;
      sh[id] = (id == 2) ? {sh[id][15:0], d} : {sh[id][18:0], d[0]};
      bc[id]++;
      if (bc[id] == bpe) begin
        bc[id] = 0;
        case (id)
          0: if (q_a.size() > 0) begin e = q_a.pop_front(); got = 1'b1; end
          1: if (q_s.size() > 0) begin e = q_s.pop_front(); got = 1'b1; end
          default: if (q_l.size() > 0) begin e = q_l.pop_front(); got = 1'b1; end
        endcase
        if (got) begin
          chk($sformatf("z_element_dut%0d", id), sh[id], e);
        end else begin
          checks++;
          failures++;
          $display("FAIL z_unexpected_dut%0d: actual=%0d required=none", id, sh[id]);
        end
      end
    end else begin
      if (!hold) bc[id] = 0;
      chk($sformatf("idle_data_zero_dut%0d", id), d, 0);
    end
  endtask

  always @(negedge clk) begin
    mon(0, tra, {3'b000, za}, hold1, donea);
    mon(1, trs, {3'b000, zs}, hold1, dones);
    mon(2, trl, zl, hold4, donel);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [19:0] a0, a1, a2, s0, s1, s2);
    q_a.push_back(a0); q_a.push_back(a1); q_a.push_back(a2);
    q_s.push_back(s0); q_s.push_back(s1); q_s.push_back(s2);
  endtask

  // init raised together with load_en and live data: that beat must not be taken.
  task automatic start1(input logic acc);
    init1 = 1'b1; acc1 = acc; le1 = 1'b1; x1 = 1'b1; y1 = 1'b1;
    tick();
    init1 = 1'b0; acc1 = 1'b0; le1 = 1'b0; x1 = 1'b0; y1 = 1'b0;
  endtask

  task automatic start4(input logic acc);
    init4 = 1'b1; acc4 = acc; le4 = 1'b1; x4 = 4'hF; y4 = 4'hF;
    tick();
    init4 = 1'b0; acc4 = 1'b0; le4 = 1'b0; x4 = 4'h0; y4 = 4'h0;
  endtask

  task automatic load1(input logic [71:0] xb, input logic [23:0] yb, input bit gaps, input int nbeats);
    for (int b = 0; b < nbeats; b++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 2);
        for (int k = 0; k < g; k++) begin
          le1 = 1'b0; x1 = 1'($urandom); y1 = 1'($urandom);
          tick();
        end
      end
      le1 = 1'b1;
      x1  = xb[71-b];
      y1  = (b < 24) ? yb[23-b] : 1'($urandom);
      tick();
    end
    le1 = 1'b0;
  endtask

  task automatic load4(input logic [71:0] xb, input logic [23:0] yb, input bit gaps);
    for (int b = 0; b < 18; b++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 3);
        for (int k = 0; k < g; k++) begin
          le4 = 1'b0; x4 = 4'($urandom); y4 = 4'($urandom);
          tick();
        end
      end
      le4 = 1'b1;
      x4  = xb[71-4*b -: 4];
      y4  = (b < 6) ? yb[23-4*b -: 4] : 4'($urandom);
      tick();
    end
    le4 = 1'b0;
  endtask

  task automatic run_lane1(input string nm, input logic [71:0] xb, input logic [23:0] yb,
                           input logic acc, input bit rnd);
    int b0, b1, t0, t1, lat, n;
    start1(acc);
    b0 = dn[0]; b1 = dn[1]; t0 = txb[0]; t1 = txb[1];
    load1(xb, yb, rnd, 72);
    if (!rnd) begin
      lat = 1;
      while (!tra && lat < 200) begin tick(); lat++; end
      chk({nm, "_latency"}, lat, 10);
    end
    n = 0;
    while ((dn[0] == b0 || dn[1] == b1) && n < 3000) begin
      hold1 = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
      tick();
      n++;
    end
    hold1 = 1'b0;
    if (n >= 3000) begin
      checks++; failures++;
      $display("FAIL %s_timeout: actual=no_done required=done", nm);
    end
    tick(); tick();
    chk({nm, "_done_count_u"}, dn[0] - b0, 1);
    chk({nm, "_done_count_s"}, dn[1] - b1, 1);
    chk({nm, "_tx_beats_u"}, txb[0] - t0, 60);
    chk({nm, "_tx_beats_s"}, txb[1] - t1, 60);
    chk({nm, "_busy_after"}, {busya, busys}, 0);
    chk({nm, "_pending_expected"}, q_a.size() + q_s.size(), 0);
  endtask

  task automatic run_lane4(input string nm, input bit rnd);
    int b2, t2, lat, n;
    q_l.push_back(20'd14); q_l.push_back(20'd32); q_l.push_back(20'd50);
    start4(1'b0);
    b2 = dn[2]; t2 = txb[2];
    load4(X_SEQ, Y_123, rnd);
    if (!rnd) begin
      lat = 1;
      while (!trl && lat < 200) begin tick(); lat++; end
      chk({nm, "_latency"}, lat, 10);
    end
    n = 0;
    while (dn[2] == b2 && n < 3000) begin
      hold4 = rnd ? ($urandom_range(0, 2) == 0) : 1'b0;
      tick();
      n++;
    end
    hold4 = 1'b0;
    if (n >= 3000) begin
      checks++; failures++;
      $display("FAIL %s_timeout: actual=no_done required=done", nm);
    end
    tick(); tick();
    chk({nm, "_done_count"}, dn[2] - b2, 1);
    chk({nm, "_tx_beats"}, txb[2] - t2, 15);
    chk({nm, "_busy_after"}, busyl, 0);
    chk({nm, "_pending_expected"}, q_l.size(), 0);
  endtask

  initial begin
    int base, t0, n;
    rst = 1'b1;
    x1 = 1'b0; y1 = 1'b0; le1 = 1'b0; init1 = 1'b0; acc1 = 1'b0; hold1 = 1'b0;
    x4 = 4'h0; y4 = 4'h0; le4 = 1'b0; init4 = 1'b0; acc4 = 1'b0; hold4 = 1'b0;
    tick(); tick();
    chk("reset_tx_ready", {tra, trs, trl}, 0);
    chk("reset_busy", {busya, busys, busyl}, 0);
    chk("reset_done", {donea, dones, donel}, 0);
    chk("reset_data_out", {za, zs, zl}, 0);
    rst = 1'b0;
    tick();

    push1(20'd1, 20'd2, 20'd3, 20'd1, 20'd2, 20'd3);
    run_lane1("t1_identity", X_ID, Y_123, 1'b0, 1'b0);

    push1(20'd2, 20'd4, 20'd6, 20'd2, 20'd4, 20'd6);
    run_lane1("t4_accumulate", X_ID, Y_123, 1'b1, 1'b0);

    push1(20'd195075, 20'd195075, 20'd195075, 20'd3, 20'd3, 20'd3);
    run_lane1("t2_all_ff_gated", X_FF, Y_FF, 1'b0, 1'b1);

    push1(20'd49152, 20'd49152, 20'd49152, 20'd49152, 20'd49152, 20'd49152);
    run_lane1("t3_minus128", X_80, Y_80, 1'b0, 1'b0);

    push1(20'd765, 20'd765, 20'd765, 20'hFFFFD, 20'hFFFFD, 20'hFFFFD);
    run_lane1("t3_minus1", X_FF, Y_1, 1'b0, 1'b0);

    // Reset mid-load on an accumulating run; the following accumulating run must start from zero.
    start1(1'b1);
    load1(X_ID, Y_123, 1'b0, 30);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_busy", {busya, busys}, 0);
    chk("t6_rst_tx_ready", {tra, trs}, 0);
    tick();
    push1(20'd1, 20'd2, 20'd3, 20'd1, 20'd2, 20'd3);
    run_lane1("t6_acc_after_rst", X_ID, Y_123, 1'b1, 1'b0);

    // Abort during TX beat 10, then a fresh run; only the fresh run may pulse done.
    base = dn[0];
    start1(1'b0);
    load1(X_ID, Y_123, 1'b0, 72);
    t0 = txb[0];
    n = 0;
    while (txb[0] - t0 < 10 && n < 500) begin tick(); n++; end
    chk("t6_reached_tx_beat10", txb[0] - t0, 10);
    q_a.delete();
    q_s.delete();
    push1(20'd1, 20'd2, 20'd3, 20'd1, 20'd2, 20'd3);
    run_lane1("t6_restart", X_ID, Y_123, 1'b0, 1'b0);
    chk("t6_no_done_on_abort", dn[0] - base, 1);

    run_lane4("t5_lanes4_plain", 1'b0);
    run_lane4("t5_lanes4_gated", 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
